// File: rtl/dcache_sram_nway.sv
// Purpose: N-way set-associative dcache storage with true-LRU, per-line valid/dirty, and a flush walker.
// Latency: lookup/victim outputs combinational in the same cycle; writes, LRU and flush state update at clk_i.
// Backpressure: write-back offer (wb_*) held stable until wb_ready_i; accesses ignored while busy_o.
//
// Ports:
//   clk_i, rst_i (sync, active-high)   addr_i/tag_i/data_i/enable_i/write_i/dirty_i : access
//   tag_o {valid,dirty,tag}, data_o, hit_o, victim_way_o                        : lookup result
//   flush_i, busy_o, flush_done_o                                                 : flush control
//   wb_valid_o/wb_ready_i, wb_addr_o, wb_tag_o, wb_data_o                         : dirty-line write-back
module dcache_sram_nway #(
   parameter int WAYS   = 4,
   parameter int SETS   = 16,
   parameter int TAG_W  = 23,
   parameter int LINE_W = 256,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic              dirty_i,
   input  logic              flush_i,
   output logic [TAG_W+1:0]  tag_o,
   output logic [LINE_W-1:0] data_o,
   output logic              hit_o,
   output logic [WAY_W-1:0]  victim_way_o,
   output logic              busy_o,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [IDX_W-1:0]  wb_addr_o,
   output logic [TAG_W-1:0]  wb_tag_o,
   output logic [LINE_W-1:0] wb_data_o,
   output logic              flush_done_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Flush pointer is {set, way}, so a plain increment walks set-major, way-minor.
   localparam int PTR_W = IDX_W + WAY_W;

   // Tag/data storage is never reset; valid bits gate every use of it.
   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [LINE_W-1:0] data_mem [SETS][WAYS];

   logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0]            dirty_q, dirty_d;
   logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q, age_d;
   logic [1:0]                           state_q, state_d;
   logic [PTR_W-1:0]                     ptr_q, ptr_d;

   logic             busy, look_en, wr_en, acc_en;
   logic             hit_raw, inv_found;
   logic [WAY_W-1:0] hit_way, inv_way, old_way, victim_way, sel_way;
   logic [IDX_W-1:0] ptr_set;
   logic [WAY_W-1:0] ptr_way;
   logic             ptr_last;

   assign busy     = (state_q != ST_IDLE);
   assign look_en  = enable_i & ~busy;
   assign ptr_set  = ptr_q[PTR_W-1:WAY_W];
   assign ptr_way  = ptr_q[WAY_W-1:0];
   assign ptr_last = &ptr_q;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit_raw   = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      old_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[addr_i][w] && (tag_mem[addr_i][w] == tag_i)) begin
            hit_raw = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[addr_i][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (age_q[addr_i][w] == WAY_W'(WAYS - 1)) begin
            old_way = WAY_W'(w);
         end
      end
   end

   assign victim_way = inv_found ? inv_way : old_way;
   // Hit way on a hit, otherwise the victim: this is both the displayed line and the write target.
   assign sel_way    = hit_raw ? hit_way : victim_way;
   assign wr_en      = look_en & write_i;
   assign acc_en     = look_en & (write_i | hit_raw);

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tag_mem[addr_i][sel_way]  <= tag_i;
         data_mem[addr_i][sel_way] <= data_i;
      end
   end

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      age_d   = age_q;
      state_d = state_q;
      ptr_d   = ptr_q;

      if (wr_en) begin
         valid_d[addr_i][sel_way] = 1'b1;
         dirty_d[addr_i][sel_way] = dirty_i;
      end

      // Ages stay a permutation of 0..WAYS-1: accessed way goes to 0, younger ones shift up by one.
      if (acc_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == sel_way) begin
               age_d[addr_i][w] = '0;
            end else if (age_q[addr_i][w] < age_q[addr_i][sel_way]) begin
               age_d[addr_i][w] = age_q[addr_i][w] + WAY_W'(1);
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (flush_i) begin
               state_d = ST_SCAN;
               ptr_d   = '0;
            end
         end
         ST_SCAN: begin
            if (valid_q[ptr_set][ptr_way] && dirty_q[ptr_set][ptr_way]) begin
               state_d = ST_WB;
            end else begin
               valid_d[ptr_set][ptr_way] = 1'b0;
               ptr_d = ptr_q + PTR_W'(1);
               if (ptr_last) state_d = ST_DONE;
            end
         end
         ST_WB: begin
            if (wb_ready_i) begin
               valid_d[ptr_set][ptr_way] = 1'b0;
               dirty_d[ptr_set][ptr_way] = 1'b0;
               ptr_d   = ptr_q + PTR_W'(1);
               state_d = ptr_last ? ST_DONE : ST_SCAN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         valid_q <= '0;
         dirty_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               age_q[s][w] <= WAY_W'(w);
            end
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         age_q   <= age_d;
      end
   end

   assign hit_o        = look_en & hit_raw;
   assign tag_o        = look_en ? {valid_q[addr_i][sel_way], dirty_q[addr_i][sel_way],
                                    tag_mem[addr_i][sel_way]} : '0;
   assign data_o       = look_en ? data_mem[addr_i][sel_way] : '0;
   assign victim_way_o = victim_way;
   assign busy_o       = busy;
   assign flush_done_o = (state_q == ST_DONE);

   // Writes are blocked while busy, so the offered entry cannot change under the walker.
   assign wb_valid_o = (state_q == ST_WB);
   assign wb_addr_o  = ptr_set;
   assign wb_tag_o   = tag_mem[ptr_set][ptr_way];
   assign wb_data_o  = data_mem[ptr_set][ptr_way];

endmodule
